// File: rtl/id_ex_issue_stage.sv
// ---------------------------------------------------------------------------
// id_ex_issue_stage
// Decode/issue stage between IF/ID and execute. Decodes one RV32I instruction
// into ALU control, immediate and memory/writeback controls, and captures the
// result together with the PC and register operands into the ID/EX register.
//
// Handshake (both sides): a beat moves when valid & ready are high at the same
// rising edge. Upstream may present data with in_valid=1 at any time and must
// hold it until in_ready=1. out_valid/out_* stay constant until out_ready=1
// (stall). in_ready = !out_valid | out_ready, so a full register whose content
// is being consumed can accept a new beat in the same cycle. A flush kills the
// held instruction and drops whatever is on the input that cycle.
// ---------------------------------------------------------------------------
module id_ex_issue_stage #(
    parameter int              XLEN   = 32,
    parameter logic [XLEN-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst,

    // upstream (IF/ID) side
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,

    // branch redirect
    input  logic            flush,

    // downstream (execute) side
    input  logic            out_ready,
    output logic            out_valid,
    output logic [1:0]      ALUop,
    output logic            alusrc,
    output logic [2:0]      funct3,
    output logic            funct7_30,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic [4:0]      rd_addr,
    output logic            regwrite,
    output logic            memread,
    output logic            memwrite,
    output logic            memtoreg,
    output logic            branch,
    output logic            illegal
);

    // -----------------------------------------------------------------------
    // Opcodes handled by this stage
    // -----------------------------------------------------------------------
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_RTYP = 2'b10;
    localparam logic [1:0] ALUOP_ITYP = 2'b11;

    // shift-right funct3 (SRLI/SRAI use instr[30] to pick logical/arith)
    localparam logic [2:0] F3_SR = 3'b101;

    // Decoded control bundle, produced combinationally from instr
    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       f7_30;
        logic       reg_wr;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       is_branch;
        logic       is_illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_ZERO = '0;

    // -----------------------------------------------------------------------
    // Instruction fields
    // -----------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [4:0]      rd_f;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign rd_f   = instr[11:7];

    // rs1/rs2 indices are consumed by the register file, not by this stage
    logic unused_rs1_idx;
    assign unused_rs1_idx = ^instr[19:15];

    // Sign-extended immediates for every format the stage supports
    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25],
                    instr[11:8], 1'b0};

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] dec_imm;

    // Opcode decode to control bundle and immediate; unknown opcodes flag illegal
    always_comb begin
        dec_ctrl = CTRL_ZERO;
        dec_imm  = '0;
        unique case (opcode)
            OP_R: begin
                dec_ctrl.alu_op  = ALUOP_RTYP;
                dec_ctrl.alu_src = 1'b0;
                dec_ctrl.f7_30   = instr[30];
                dec_ctrl.reg_wr  = 1'b1;
            end
            OP_I_ALU: begin
                dec_ctrl.alu_op  = ALUOP_ITYP;
                dec_ctrl.alu_src = 1'b1;
                // only shifts look at bit 30, so ADDI with a negative
                // immediate never turns into a subtract
                dec_ctrl.f7_30   = (f3 == F3_SR) ? instr[30] : 1'b0;
                dec_ctrl.reg_wr  = 1'b1;
                dec_imm          = imm_i;
            end
            OP_LOAD: begin
                dec_ctrl.alu_op     = ALUOP_ADD;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.mem_rd     = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.reg_wr     = 1'b1;
                dec_imm             = imm_i;
            end
            OP_STORE: begin
                dec_ctrl.alu_op  = ALUOP_ADD;
                dec_ctrl.alu_src = 1'b1;
                dec_ctrl.mem_wr  = 1'b1;
                dec_imm          = imm_s;
            end
            OP_BRANCH: begin
                dec_ctrl.alu_op    = ALUOP_SUB;
                dec_ctrl.alu_src   = 1'b0;
                dec_ctrl.is_branch = 1'b1;
                dec_imm            = imm_b;
            end
            default: begin
                dec_ctrl.is_illegal = 1'b1;
            end
        endcase
        // writes to x0 are architecturally discarded; suppress them here
        if (rd_f == 5'd0) begin
            dec_ctrl.reg_wr = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    logic in_xfer;
    logic out_xfer;
    logic load_en;

    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign load_en  = in_xfer && !flush;

    // Valid bit: flush wins, then a new beat, then drain; otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // ID/EX payload register
    // -----------------------------------------------------------------------
    ctrl_t ctrl_q;

    // Payload only changes on an accepted, non-flushed beat; stalls hold it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= CTRL_ZERO;
            funct3  <= 3'b000;
            imm     <= '0;
            pc      <= RST_PC;
            rd1     <= '0;
            rd2     <= '0;
            rd_addr <= 5'd0;
        end else if (load_en) begin
            ctrl_q  <= dec_ctrl;
            funct3  <= f3;
            imm     <= dec_imm;
            pc      <= pc_in;
            rd1     <= rs1_data;
            rd2     <= rs2_data;
            rd_addr <= rd_f;
        end
    end

    assign ALUop     = ctrl_q.alu_op;
    assign alusrc    = ctrl_q.alu_src;
    assign funct7_30 = ctrl_q.f7_30;
    assign regwrite  = ctrl_q.reg_wr;
    assign memread   = ctrl_q.mem_rd;
    assign memwrite  = ctrl_q.mem_wr;
    assign memtoreg  = ctrl_q.mem_to_reg;
    assign branch    = ctrl_q.is_branch;
    assign illegal   = ctrl_q.is_illegal;

endmodule
